uart_bus_master: RTL and testbench
==================================

Name: uart_bus_master

Overview:
- Command sequencer that sits on the host side of the 8-bit uart block.
- Consumes received bytes, parses read/write command frames and performs single-byte transactions on a simple req/ack register bus.
- Returns a response byte through the uart transmitter.
- Also supplies the static uart configuration (control word, baud divisor), so the uart needs no other master.

Parameters:
- BAUD, 16'd433, divisor driven onto uart_baudrate (bit period = BAUD+1 clk).
- CTRL, 8'h50, uart control word (RX enable bit4, TX enable bit6, 8-bit mode).
- BYTE_TMO, 20'd100000, max clk cycles between bytes of one frame.
- BUS_TMO, 8'd255, max clk cycles waiting for bus_ack.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- uart_control  out  8  constant CTRL
- uart_baudrate  out  16  constant BAUD
- rx_valid  in  1  uart rx byte available
- rxdata  in  8  uart rx byte
- uart_status  in  8  uart status; bits[4:2] = noise/framing/parity of current rx byte
- read_rx  out  1  one-cycle pop of uart rx byte
- tx_empty  in  1  uart tx buffer can accept a byte
- txdata  out  8  byte to transmit
- write_tx  out  1  one-cycle push of txdata
- bus_req  out  1  bus transaction request, held until ack or timeout
- bus_write  out  1  1 = write, 0 = read; valid with bus_req
- bus_addr  out  16  transaction address
- bus_wdata  out  8  write data
- bus_rdata  in  8  read data, valid with bus_ack
- bus_ack  in  1  one-cycle transaction completion
- busy  out  1  state != IDLE
- err_count  out  8  saturating count of aborted frames

Behaviour:
- Reset: state IDLE. All outputs 0 except uart_control = CTRL and uart_baudrate = BAUD. err_count = 0. The reset is asynchronous, so it returns to IDLE even mid-frame.

Frame format:
- Write: 0x57 AH AL D. Response 0x06.
- Read: 0x52 AH AL. Response is the read data byte.
- Failure response: 0x15 (NAK).

Byte intake:
- In IDLE, ADDRH, ADDRL and DATA, the block asserts read_rx for exactly one cycle in the same cycle it sees rx_valid=1, and samples rxdata/uart_status that cycle.
- read_rx is never asserted on two consecutive cycles.
- read_rx is never asserted outside these four states.

State machine:
- IDLE:
  - 0x57 or 0x52 with uart_status[4:2]=0: latch cmd, go to ADDRH.
  - Any other byte: go to RESP with NAK, err_count+1.
- ADDRH: latch bus_addr[15:8], go to ADDRL.
- ADDRL: latch bus_addr[7:0]; write goes to DATA, read goes to BUS.
- DATA: latch bus_wdata, go to BUS.
- BUS:
  - bus_req=1 and bus_write=cmd from the first cycle of BUS.
  - On bus_ack: drop bus_req the next cycle. Response = 0x06 (write) or bus_rdata captured in the ack cycle (read). Go to RESP.
  - BUS_TMO cycles with no ack: drop bus_req, response NAK, err_count+1, go to RESP.
  - bus_ack outside BUS is ignored.
- RESP:
  - Wait for tx_empty=1, then pulse write_tx one cycle with txdata = response. txdata holds until the next response.
  - Return to IDLE the cycle after write_tx.

Error handling:
- In ADDRH/ADDRL/DATA, a byte with any uart_status[4:2] set is popped, then NAK is sent and err_count+1.
- Inter-byte timer resets on every popped byte.
- In ADDRH/ADDRL/DATA, reaching BYTE_TMO cycles without a byte returns to IDLE silently (no response) with err_count+1.
- err_count saturates at 8'hFF.

Bus and response rules:
- Latency from last popped byte to bus_req = 1 clk.
- bus_addr and bus_wdata are stable while bus_req=1.
- Exactly one response byte per completed or failed frame; a byte-timeout frame produces none.
- Bytes arriving during BUS/RESP stay in the uart (not popped); they are parsed after returning to IDLE.

Test Plan:
- Write frame 57 12 34 A5; ack after 3 clk -> bus_req with bus_write=1, addr 0x1234, wdata 0xA5; one write_tx with 0x06; err_count 0.
- Read frame 52 00 10; bus_rdata=0x3C with ack -> bus_req with bus_write=0, addr 0x0010; txdata 0x3C; back to IDLE, busy=0.
- Byte 0x41 in IDLE -> one read_rx, NAK 0x15 transmitted, err_count=1; no bus_req.
- 57 12 then silence > BYTE_TMO -> return to IDLE, no tx byte, err_count+1; next valid frame succeeds.
- Read frame with bus_ack never asserted -> bus_req drops after BUS_TMO cycles, NAK sent; hold tx_empty=0 for 50 clk -> write_tx delayed until tx_empty=1.
- nreset asserted during BUS -> bus_req, write_tx, read_rx = 0 immediately; state IDLE, err_count 0.

Source files
------------

// File: rtl/uart_bus_master_if.sv
// Handshake bundle between uart_bus_master, the 8-bit uart (rx/tx side)
// and the single-byte req/ack register bus.
interface uart_bus_master_if;
  logic        rx_valid;
  logic [7:0]  rxdata;
  logic [7:0]  uart_status;
  logic        read_rx;
  logic        tx_empty;
  logic [7:0]  txdata;
  logic        write_tx;
  logic        bus_req;
  logic        bus_write;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;

  modport master (
    input  rx_valid, rxdata, uart_status, tx_empty, bus_rdata, bus_ack,
    output read_rx, txdata, write_tx, bus_req, bus_write, bus_addr, bus_wdata
  );

  modport slave (
    output rx_valid, rxdata, uart_status, tx_empty, bus_rdata, bus_ack,
    input  read_rx, txdata, write_tx, bus_req, bus_write, bus_addr, bus_wdata
  );
endinterface

// File: rtl/uart_bus_master.sv
// Host-side command sequencer for the 8-bit uart: parses 0x57/0x52 frames,
// runs one req/ack bus transaction per frame and answers with one byte.
module uart_bus_master #(
  parameter logic [15:0] BAUD     = 16'd433,
  parameter logic [7:0]  CTRL     = 8'h50,
  parameter logic [19:0] BYTE_TMO = 20'd100000,
  parameter logic [7:0]  BUS_TMO  = 8'd255
) (
  input  logic        clk,
  input  logic        nreset,
  output logic [7:0]  uart_control,
  output logic [15:0] uart_baudrate,
  output logic        busy,
  output logic [7:0]  err_count,
  uart_bus_master_if.master bif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDRH = 3'd1;
  localparam logic [2:0] ADDRL = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] BUS   = 3'd4;
  localparam logic [2:0] RESP  = 3'd5;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  logic [2:0]  state_r;
  logic        cmd_write_r;
  logic        rx_gap_r;
  logic [19:0] byte_tmr_r;
  logic [7:0]  bus_tmr_r;
  logic [7:0]  resp_r;
  logic [7:0]  err_count_r;
  logic        busy_r;
  logic        write_tx_r;
  logic [7:0]  txdata_r;
  logic        bus_req_r;
  logic        bus_write_r;
  logic [15:0] bus_addr_r;
  logic [7:0]  bus_wdata_r;
  logic        intake_s;
  logic        status_ok_s;
  logic        read_rx_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  assign uart_control  = CTRL;
  assign uart_baudrate = BAUD;
  assign busy          = busy_r;
  assign err_count     = err_count_r;
  assign bif.txdata    = txdata_r;
  assign bif.write_tx  = write_tx_r;
  assign bif.bus_req   = bus_req_r;
  assign bif.bus_write = bus_write_r;
  assign bif.bus_addr  = bus_addr_r;
  assign bif.bus_wdata = bus_wdata_r;
  assign bif.read_rx   = read_rx_s;

  // Pop decode: rx_gap_r comes out of reset set, which also keeps read_rx low during reset.
  always_comb begin
    intake_s    = (state_r == IDLE) || (state_r == ADDRH) ||
                  (state_r == ADDRL) || (state_r == DATA);
    status_ok_s = (bif.uart_status[4:2] == 3'b000);
    read_rx_s   = intake_s && bif.rx_valid && !rx_gap_r;
  end

  // Frame sequencer, bus handshake and response transmitter.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r     <= IDLE;
      cmd_write_r <= 1'b0;
      rx_gap_r    <= 1'b1;
      byte_tmr_r  <= 20'd0;
      bus_tmr_r   <= 8'd0;
      resp_r      <= 8'h00;
      err_count_r <= 8'h00;
      busy_r      <= 1'b0;
      write_tx_r  <= 1'b0;
      txdata_r    <= 8'h00;
      bus_req_r   <= 1'b0;
      bus_write_r <= 1'b0;
      bus_addr_r  <= 16'h0000;
      bus_wdata_r <= 8'h00;
    end else begin
      rx_gap_r   <= read_rx_s;
      write_tx_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (read_rx_s) begin
            byte_tmr_r <= 20'd0;
            busy_r     <= 1'b1;
            if (((bif.rxdata == CMD_W) || (bif.rxdata == CMD_R)) && status_ok_s) begin
              cmd_write_r <= (bif.rxdata == CMD_W);
              state_r     <= ADDRH;
            end else begin
              resp_r      <= NAK;
              err_count_r <= sat_inc(err_count_r);
              state_r     <= RESP;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ADDRH, ADDRL, DATA: begin
          if (read_rx_s && !status_ok_s) begin
            resp_r      <= NAK;
            err_count_r <= sat_inc(err_count_r);
            state_r     <= RESP;
          end else if (read_rx_s) begin
            byte_tmr_r <= 20'd0;
            if (state_r == ADDRH) begin
              bus_addr_r[15:8] <= bif.rxdata;
              state_r          <= ADDRL;
            end else if (state_r == ADDRL) begin
              bus_addr_r[7:0] <= bif.rxdata;
              if (cmd_write_r) begin
                state_r <= DATA;
              end else begin
                bus_tmr_r   <= 8'd0;
                bus_req_r   <= 1'b1;
                bus_write_r <= 1'b0;
                state_r     <= BUS;
              end
            end else begin
              bus_wdata_r <= bif.rxdata;
              bus_tmr_r   <= 8'd0;
              bus_req_r   <= 1'b1;
              bus_write_r <= 1'b1;
              state_r     <= BUS;
            end
          end else if (byte_tmr_r >= (BYTE_TMO - 20'd1)) begin
            // Stalled frame: abandon without a response byte.
            err_count_r <= sat_inc(err_count_r);
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            byte_tmr_r <= byte_tmr_r + 20'd1;
          end
        end
        BUS: begin
          if (bif.bus_ack) begin
            bus_req_r   <= 1'b0;
            bus_write_r <= 1'b0;
            resp_r      <= cmd_write_r ? ACK : bif.bus_rdata;
            state_r     <= RESP;
          end else if (bus_tmr_r >= (BUS_TMO - 8'd1)) begin
            bus_req_r   <= 1'b0;
            bus_write_r <= 1'b0;
            resp_r      <= NAK;
            err_count_r <= sat_inc(err_count_r);
            state_r     <= RESP;
          end else begin
            bus_tmr_r <= bus_tmr_r + 8'd1;
          end
        end
        RESP: begin
          if (write_tx_r) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (bif.tx_empty) begin
            write_tx_r <= 1'b1;
            txdata_r   <= resp_r;
          end else begin
            write_tx_r <= 1'b0;
          end
        end
        default: begin
          bus_req_r   <= 1'b0;
          bus_write_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: expected bus transactions and
// response bytes are queued at stimulus time and retired by monitors.
module tb_uart_bus_master;

  localparam logic [19:0] TB_BYTE_TMO = 20'd200;

  typedef struct packed {
    logic        chk_wdata;
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } bus_t;

  logic        clk;
  logic        nreset;
  logic [7:0]  uart_control;
  logic [15:0] uart_baudrate;
  logic        busy;
  logic [7:0]  err_count;

  uart_bus_master_if bif ();

  uart_bus_master #(.BYTE_TMO(TB_BYTE_TMO)) dut (
    .clk           (clk),
    .nreset        (nreset),
    .uart_control  (uart_control),
    .uart_baudrate (uart_baudrate),
    .busy          (busy),
    .err_count     (err_count),
    .bif           (bif)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   tx_seen  = 0;
  bus_t exp_bus[$];
  logic [7:0] exp_tx[$];
  logic prev_req = 1'b0;
  logic prev_rd  = 1'b0;
  bus_t cur_bus;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // read_rx must never fire on two consecutive cycles
  always @(posedge clk) begin
    if (bif.read_rx) check("rd_gap", {31'd0, prev_rd}, 32'd0);
    prev_rd <= bif.read_rx;
  end

  // Response and bus monitors retire scoreboard entries.
  always @(negedge clk) begin
    if (bif.write_tx) begin
      tx_seen++;
      if (exp_tx.size() == 0) check("tx_extra", {24'd0, bif.txdata}, 32'hFFFF_FFFF);
      else check("tx_byte", {24'd0, bif.txdata}, {24'd0, exp_tx.pop_front()});
    end
    if (bif.bus_req && !prev_req) begin
      if (exp_bus.size() == 0) begin
        check("bus_extra", 32'd1, 32'd0);
      end else begin
        cur_bus = exp_bus.pop_front();
        check("bus_write", {31'd0, bif.bus_write}, {31'd0, cur_bus.write});
        check("bus_addr", {16'd0, bif.bus_addr}, {16'd0, cur_bus.addr});
        if (cur_bus.chk_wdata) check("bus_wdata", {24'd0, bif.bus_wdata}, {24'd0, cur_bus.wdata});
      end
    end else if (bif.bus_req && (bif.bus_addr !== cur_bus.addr)) begin
      check("bus_addr_stable", {16'd0, bif.bus_addr}, {16'd0, cur_bus.addr});
    end
    prev_req <= bif.bus_req;
  end

  task automatic send_byte(input logic [7:0] b, input logic [7:0] st);
    int n;
    bif.rxdata      = b;
    bif.uart_status = st;
    bif.rx_valid    = 1'b1;
    n = 0;
    #1;
    while (!bif.read_rx && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) check("rx_pop_tmo", 32'd0, 32'd1);
    @(negedge clk);
    bif.rx_valid    = 1'b0;
    bif.uart_status = 8'h00;
  endtask

  task automatic do_ack(input int delay, input logic [7:0] rdata);
    for (int i = 0; i < delay; i++) @(negedge clk);
    bif.bus_rdata = rdata;
    bif.bus_ack   = 1'b1;
    @(negedge clk);
    bif.bus_ack   = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int waited);
    waited = 0;
    while (busy && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= limit) check("idle_tmo", 32'd0, 32'd1);
  endtask

  initial begin
    int w;
    int seen0;
    nreset          = 1'b0;
    bif.rx_valid    = 1'b0;
    bif.rxdata      = 8'h00;
    bif.uart_status = 8'h00;
    bif.tx_empty    = 1'b1;
    bif.bus_rdata   = 8'h00;
    bif.bus_ack     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {24'd0, uart_control}, 32'h50);
    check("rst_baud", {16'd0, uart_baudrate}, 32'd433);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {24'd0, err_count}, 32'd0);
    check("rst_outs", {29'd0, bif.bus_req, bif.write_tx, bif.read_rx}, 32'd0);
    check("rst_txdata", {24'd0, bif.txdata}, 32'd0);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    // write frame, ack after 3 clk
    exp_bus.push_back('{1'b1, 1'b1, 16'h1234, 8'hA5});
    exp_tx.push_back(8'h06);
    send_byte(8'h57, 8'h00);
    send_byte(8'h12, 8'h00);
    send_byte(8'h34, 8'h00);
    send_byte(8'hA5, 8'h00);
    check("req_latency", {31'd0, bif.bus_req}, 32'd1);
    do_ack(3, 8'h99);
    wait_idle(50, w);
    check("wr_err", {24'd0, err_count}, 32'd0);

    // read frame returning 0x3C
    exp_bus.push_back('{1'b0, 1'b0, 16'h0010, 8'h00});
    exp_tx.push_back(8'h3C);
    send_byte(8'h52, 8'h00);
    send_byte(8'h00, 8'h00);
    send_byte(8'h10, 8'h00);
    do_ack(1, 8'h3C);
    wait_idle(50, w);
    check("rd_busy", {31'd0, busy}, 32'd0);

    // bad command byte
    exp_tx.push_back(8'h15);
    send_byte(8'h41, 8'h00);
    wait_idle(50, w);
    check("badcmd_err", {24'd0, err_count}, 32'd1);

    // good command byte with framing error flagged
    exp_tx.push_back(8'h15);
    send_byte(8'h57, 8'h08);
    wait_idle(50, w);
    check("stat_err", {24'd0, err_count}, 32'd2);

    // byte timeout mid-frame, then a good frame
    seen0 = tx_seen;
    send_byte(8'h57, 8'h00);
    send_byte(8'h12, 8'h00);
    wait_idle(400, w);
    check("btmo_min", {31'd0, w >= int'(TB_BYTE_TMO) - 2}, 32'd1);
    check("btmo_err", {24'd0, err_count}, 32'd3);
    check("btmo_notx", tx_seen - seen0, 32'd0);
    exp_bus.push_back('{1'b1, 1'b1, 16'hABCD, 8'hEF});
    exp_tx.push_back(8'h06);
    send_byte(8'h57, 8'h00);
    send_byte(8'hAB, 8'h00);
    send_byte(8'hCD, 8'h00);
    send_byte(8'hEF, 8'h00);
    do_ack(0, 8'h00);
    wait_idle(50, w);
    check("after_tmo_err", {24'd0, err_count}, 32'd3);

    // bus timeout with tx held full
    bif.tx_empty = 1'b0;
    exp_bus.push_back('{1'b0, 1'b0, 16'h5555, 8'h00});
    exp_tx.push_back(8'h15);
    send_byte(8'h52, 8'h00);
    send_byte(8'h55, 8'h00);
    send_byte(8'h55, 8'h00);
    w = 0;
    while (bif.bus_req && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("bus_tmo_len", w, 32'd255);
    seen0 = tx_seen;
    repeat (50) @(negedge clk);
    check("tx_held", tx_seen - seen0, 32'd0);
    check("tx_held_busy", {31'd0, busy}, 32'd1);
    bif.tx_empty = 1'b1;
    wait_idle(50, w);
    check("tx_released", tx_seen - seen0, 32'd1);
    check("bus_tmo_err", {24'd0, err_count}, 32'd4);

    // asynchronous reset during BUS
    exp_bus.push_back('{1'b1, 1'b1, 16'h0001, 8'h02});
    send_byte(8'h57, 8'h00);
    send_byte(8'h00, 8'h00);
    send_byte(8'h01, 8'h00);
    send_byte(8'h02, 8'h00);
    check("pre_rst_req", {31'd0, bif.bus_req}, 32'd1);
    bif.rxdata   = 8'h52;
    bif.rx_valid = 1'b1;
    #2 nreset = 1'b0;
    #1;
    check("mid_rst_outs", {29'd0, bif.bus_req, bif.write_tx, bif.read_rx}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_err", {24'd0, err_count}, 32'd0);
    @(negedge clk);
    bif.rx_valid = 1'b0;
    nreset = 1'b1;
    repeat (3) @(negedge clk);

    check("sb_tx_empty", exp_tx.size(), 32'd0);
    check("sb_bus_empty", exp_bus.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
